// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: load/flush enables for load-use hazards,
// taken branches and data-memory wait states, plus stall/flush counters.
module pipe_ctrl #(
    parameter int HAZ_BUBBLES = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Hazard,
    input  logic        Branch_Taken,
    input  logic        Mem_Req,
    input  logic        Mem_Ready,
    input  logic        Cnt_Clr,
    output logic        IF_Ld,
    output logic        ID_Ld,
    output logic        EX_Ld,
    output logic        MEM_Ld,
    output logic        WB_Ld,
    output logic        ID_Flush,
    output logic        EX_Flush,
    output logic [1:0]  Ctrl_State,
    output logic [15:0] Stall_Cnt,
    output logic [15:0] Flush_Cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HAZ  = 2'b01,
        MEMW = 2'b10,
        BAD  = 2'b11
    } state_t;

    localparam logic [1:0] BUB_LOAD = 2'(HAZ_BUBBLES - 1);

    state_t     state, next_state;
    state_t     saved_state, next_saved;
    state_t     eff_state;
    logic [1:0] bub_cnt, next_bub;
    logic       mem_stall;

    assign mem_stall  = Mem_Req & ~Mem_Ready;
    // While waiting on memory, the released cycle behaves as the interrupted state.
    assign eff_state  = (state == MEMW) ? saved_state : state;
    assign Ctrl_State = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= RUN;
            saved_state <= RUN;
            bub_cnt     <= 2'd0;
        end else begin
            state       <= next_state;
            saved_state <= next_saved;
            bub_cnt     <= next_bub;
        end
    end

    always_comb begin
        next_state = state;
        next_saved = saved_state;
        next_bub   = bub_cnt;
        IF_Ld      = 1'b1;
        ID_Ld      = 1'b1;
        EX_Ld      = 1'b1;
        MEM_Ld     = 1'b1;
        WB_Ld      = 1'b1;
        ID_Flush   = 1'b0;
        EX_Flush   = 1'b0;

        if (mem_stall) begin
            IF_Ld  = 1'b0;
            ID_Ld  = 1'b0;
            EX_Ld  = 1'b0;
            MEM_Ld = 1'b0;
            WB_Ld  = 1'b0;
            if (state == RUN || state == HAZ) begin
                next_state = MEMW;
                next_saved = state;
            end
        end else if (Branch_Taken) begin
            ID_Flush   = 1'b1;
            EX_Flush   = 1'b1;
            next_state = RUN;
            next_saved = RUN;
            next_bub   = 2'd0;
        end else begin
            next_saved = RUN;
            case (eff_state)
                RUN: begin
                    next_state = RUN;
                    if (Hazard) begin
                        IF_Ld    = 1'b0;
                        ID_Ld    = 1'b0;
                        EX_Flush = 1'b1;
                        next_bub = BUB_LOAD;
                        if (HAZ_BUBBLES > 1) begin
                            next_state = HAZ;
                        end
                    end
                end
                HAZ: begin
                    IF_Ld    = 1'b0;
                    ID_Ld    = 1'b0;
                    EX_Flush = 1'b1;
                    if (bub_cnt <= 2'd1) begin
                        next_bub   = 2'd0;
                        next_state = RUN;
                    end else begin
                        next_bub   = bub_cnt - 2'd1;
                        next_state = HAZ;
                    end
                end
                default: begin
                    next_state = RUN;
                    next_bub   = 2'd0;
                end
            endcase
        end

        if (state == BAD) begin
            next_state = RUN;
            next_saved = RUN;
            next_bub   = 2'd0;
        end
    end

    // Counters saturate rather than wrap so long runs never read as short ones.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Stall_Cnt <= 16'd0;
            Flush_Cnt <= 16'd0;
        end else if (Cnt_Clr) begin
            Stall_Cnt <= 16'd0;
            Flush_Cnt <= 16'd0;
        end else begin
            if (!IF_Ld && Stall_Cnt != 16'hFFFF) begin
                Stall_Cnt <= Stall_Cnt + 16'd1;
            end
            if (ID_Flush && Flush_Cnt != 16'hFFFF) begin
                Flush_Cnt <= Flush_Cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: three instances (HAZ_BUBBLES 1..3) share
// stimulus; each directed vector names the instance whose outputs it checks.
module tb_pipe_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic Hazard = 1'b0, Branch_Taken = 1'b0, Mem_Req = 1'b0;
    logic Mem_Ready = 1'b0, Cnt_Clr = 1'b0;

    logic        if_ld [1:3];
    logic        id_ld [1:3];
    logic        ex_ld [1:3];
    logic        mem_ld[1:3];
    logic        wb_ld [1:3];
    logic        id_fl [1:3];
    logic        ex_fl [1:3];
    logic [1:0]  st    [1:3];
    logic [15:0] sc    [1:3];
    logic [15:0] fc    [1:3];

    always #5 CLK = ~CLK;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        pipe_ctrl #(.HAZ_BUBBLES(g)) u_dut (
            .CLK(CLK), .RST(RST), .Hazard(Hazard), .Branch_Taken(Branch_Taken),
            .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready), .Cnt_Clr(Cnt_Clr),
            .IF_Ld(if_ld[g]), .ID_Ld(id_ld[g]), .EX_Ld(ex_ld[g]),
            .MEM_Ld(mem_ld[g]), .WB_Ld(wb_ld[g]),
            .ID_Flush(id_fl[g]), .EX_Flush(ex_fl[g]),
            .Ctrl_State(st[g]), .Stall_Cnt(sc[g]), .Flush_Cnt(fc[g])
        );
    end

    // {IF,ID,EX,MEM,WB Ld, ID_Flush, EX_Flush, Ctrl_State}
    localparam logic [8:0] RUNALL = 9'b11111_00_00;
    localparam logic [8:0] HZR    = 9'b00111_01_00;
    localparam logic [8:0] HZH    = 9'b00111_01_01;
    localparam logic [8:0] HZM    = 9'b00111_01_10;
    localparam logic [8:0] FRZR   = 9'b00000_00_00;
    localparam logic [8:0] FRZH   = 9'b00000_00_01;
    localparam logic [8:0] FRZM   = 9'b00000_00_10;
    localparam logic [8:0] BRR    = 9'b11111_11_00;
    localparam logic [8:0] BRH    = 9'b11111_11_01;
    localparam logic [8:0] BRM    = 9'b11111_11_10;
    localparam logic [8:0] RDYM   = 9'b11111_00_10;

    logic [42:0] exp_q[$];
    string       name_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          chk = 1'b0;

    task automatic applyStimulus(input logic rst, input logic hz, input logic br,
                                 input logic mreq, input logic mrdy, input logic clr,
                                 input int sel, input logic [8:0] outs,
                                 input logic [15:0] s_exp, input logic [15:0] f_exp,
                                 input string nm, input bit do_chk);
        @(posedge CLK);
        #1;
        RST          = rst;
        Hazard       = hz;
        Branch_Taken = br;
        Mem_Req      = mreq;
        Mem_Ready    = mrdy;
        Cnt_Clr      = clr;
        if (do_chk) begin
            exp_q.push_back({2'(sel), outs, s_exp, f_exp});
            name_q.push_back(nm);
        end
        chk = do_chk;
    endtask

    task automatic checkOutput();
        logic [42:0] e, a;
        string       nm;
        int          s;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            s  = int'(e[42:41]);
            a  = {e[42:41], if_ld[s], id_ld[s], ex_ld[s], mem_ld[s], wb_ld[s],
                  id_fl[s], ex_fl[s], st[s], sc[s], fc[s]};
            if (a !== e) begin
                errors++;
                $display("[TB] FAIL %s (bubbles=%0d): got ld=%b flush=%b state=%b stall=%h flush_cnt=%h, required ld=%b flush=%b state=%b stall=%h flush_cnt=%h",
                         nm, s, a[40:36], a[35:34], a[33:32], a[31:16], a[15:0],
                         e[40:36], e[35:34], e[33:32], e[31:16], e[15:0]);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (chk) checkOutput();
    end

    initial begin
        // Reset values and single-bubble hazard
        applyStimulus(0,0,0,0,0,0, 1, RUNALL, 16'd0, 16'd0, "reset_state", 1);
        applyStimulus(1,0,0,0,0,0, 1, RUNALL, 16'd0, 16'd0, "idle_run", 1);
        applyStimulus(1,1,0,0,0,0, 1, HZR,    16'd0, 16'd0, "hz1_bubble", 1);
        applyStimulus(1,0,0,0,0,0, 1, RUNALL, 16'd1, 16'd0, "hz1_done", 1);

        // Two-bubble hazard, then Hazard held into HAZ is ignored
        applyStimulus(0,0,0,0,0,0, 2, RUNALL, 16'd0, 16'd0, "reset_b2", 1);
        applyStimulus(1,1,0,0,0,0, 2, HZR,    16'd0, 16'd0, "hz2_first", 1);
        applyStimulus(1,0,0,0,0,0, 2, HZH,    16'd1, 16'd0, "hz2_second", 1);
        applyStimulus(1,0,0,0,0,0, 2, RUNALL, 16'd2, 16'd0, "hz2_done", 1);
        applyStimulus(1,1,0,0,0,0, 2, HZR,    16'd2, 16'd0, "hz2_again", 1);
        applyStimulus(1,1,0,0,0,0, 2, HZH,    16'd3, 16'd0, "hz_ignored_in_haz", 1);
        applyStimulus(1,0,0,0,0,0, 2, RUNALL, 16'd4, 16'd0, "hz2_again_done", 1);

        // Memory wait of three cycles
        applyStimulus(0,0,0,0,0,0, 2, RUNALL, 16'd0, 16'd0, "reset_mem", 1);
        applyStimulus(1,0,0,1,0,0, 2, FRZR,   16'd0, 16'd0, "mem_freeze1", 1);
        applyStimulus(1,0,0,1,0,0, 2, FRZM,   16'd1, 16'd0, "mem_freeze2", 1);
        applyStimulus(1,0,0,1,0,0, 2, FRZM,   16'd2, 16'd0, "mem_freeze3", 1);
        applyStimulus(1,0,0,1,1,0, 2, RDYM,   16'd3, 16'd0, "mem_ready", 1);
        applyStimulus(1,0,0,0,0,0, 2, RUNALL, 16'd3, 16'd0, "mem_done", 1);

        // Branch beats hazard; memory stall beats branch
        applyStimulus(0,0,0,0,0,0, 2, RUNALL, 16'd0, 16'd0, "reset_br", 1);
        applyStimulus(1,1,1,0,0,0, 2, BRR,    16'd0, 16'd0, "br_over_hz", 1);
        applyStimulus(1,0,0,0,0,0, 2, RUNALL, 16'd0, 16'd1, "br_done", 1);
        applyStimulus(1,0,1,1,0,0, 2, FRZR,   16'd0, 16'd1, "mem_over_br", 1);
        applyStimulus(1,0,1,1,1,0, 2, BRM,    16'd1, 16'd1, "br_on_ready", 1);
        applyStimulus(1,0,0,0,0,0, 2, RUNALL, 16'd1, 16'd2, "br_ready_done", 1);

        // Branch in HAZ discards remaining bubbles
        applyStimulus(0,0,0,0,0,0, 3, RUNALL, 16'd0, 16'd0, "reset_b3", 1);
        applyStimulus(1,1,0,0,0,0, 3, HZR,    16'd0, 16'd0, "hz3_first", 1);
        applyStimulus(1,0,1,0,0,0, 3, BRH,    16'd1, 16'd0, "br_in_haz", 1);
        applyStimulus(1,0,0,0,0,0, 3, RUNALL, 16'd1, 16'd1, "br_in_haz_done", 1);

        // Memory stall entered on bubble 2 of 3
        applyStimulus(0,0,0,0,0,0, 3, RUNALL, 16'd0, 16'd0, "reset_hzmem", 1);
        applyStimulus(1,1,0,0,0,0, 3, HZR,    16'd0, 16'd0, "hzmem_b1", 1);
        applyStimulus(1,0,0,1,0,0, 3, FRZH,   16'd1, 16'd0, "hzmem_freeze1", 1);
        applyStimulus(1,0,0,1,0,0, 3, FRZM,   16'd2, 16'd0, "hzmem_freeze2", 1);
        applyStimulus(1,0,0,1,1,0, 3, HZM,    16'd3, 16'd0, "hzmem_resume", 1);
        applyStimulus(1,0,0,0,0,0, 3, HZH,    16'd4, 16'd0, "hzmem_last", 1);
        applyStimulus(1,0,0,0,0,0, 3, RUNALL, 16'd5, 16'd0, "hzmem_done", 1);

        // Reset mid-HAZ leaves no residual bubble
        applyStimulus(1,1,0,0,0,0, 3, HZR,    16'd5, 16'd0, "rsthaz_enter", 1);
        applyStimulus(0,0,0,0,0,0, 3, RUNALL, 16'd0, 16'd0, "rsthaz_async", 1);
        applyStimulus(1,0,0,0,0,0, 3, RUNALL, 16'd0, 16'd0, "rsthaz_release", 1);

        // Reset mid-MEMW
        applyStimulus(1,0,0,1,0,0, 2, FRZR,   16'd0, 16'd0, "rstmem_freeze1", 1);
        applyStimulus(1,0,0,1,0,0, 2, FRZM,   16'd1, 16'd0, "rstmem_freeze2", 1);
        applyStimulus(0,0,0,1,0,0, 2, FRZR,   16'd0, 16'd0, "rstmem_async", 1);
        applyStimulus(1,0,0,0,0,0, 2, RUNALL, 16'd0, 16'd0, "rstmem_release", 1);
        applyStimulus(1,0,0,0,0,0, 2, RUNALL, 16'd0, 16'd0, "rstmem_run", 1);

        // Stall counter saturation and clear under an active stall
        applyStimulus(0,0,0,0,0,0, 1, RUNALL, 16'd0, 16'd0, "reset_sat", 1);
        applyStimulus(1,0,0,1,0,0, 1, FRZR,   16'd0, 16'd0, "sat_stall1", 1);
        for (int i = 0; i < 65533; i++) begin
            applyStimulus(1,0,0,1,0,0, 1, FRZM, 16'd0, 16'd0, "fill", 0);
        end
        applyStimulus(1,0,0,1,0,0, 1, FRZM,   16'hFFFE, 16'd0, "sat_fffe", 1);
        applyStimulus(1,0,0,1,0,0, 1, FRZM,   16'hFFFF, 16'd0, "sat_ffff", 1);
        applyStimulus(1,0,0,1,0,0, 1, FRZM,   16'hFFFF, 16'd0, "sat_hold", 1);
        applyStimulus(1,0,0,1,0,1, 1, FRZM,   16'hFFFF, 16'd0, "clr_cycle", 1);
        applyStimulus(1,0,0,1,0,0, 1, FRZM,   16'd0,    16'd0, "clr_done", 1);
        applyStimulus(1,0,0,1,1,0, 1, RDYM,   16'd1,    16'd0, "sat_ready", 1);
        applyStimulus(1,0,0,0,0,0, 1, RUNALL, 16'd1,    16'd0, "sat_run", 1);

        applyStimulus(1,0,0,0,0,0, 1, RUNALL, 16'd0, 16'd0, "tail", 0);
        @(posedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
